bram_packet_streamer: RTL and testbench
=======================================

Name: bram_packet_streamer

Overview:
- Downstream stage of the data generator/BRAM writer.
- Reads fixed-size packets (default 144 words) out of the shared BRAM ring buffer through BRAM port B, once the writer's word pointer shows a complete packet is present.
- Emits the packets as an AXI4-Stream master toward the DMA/PS.
- Reports progress and overrun in status words for the status register bank.

Parameters:
- BRAM_ADDR_WIDTH, 16, byte address width of port B.
- BRAM_DEPTH_WORDS, 16384, ring size in 32-bit words; power of two.
- PACKET_WORDS, 144, words per packet.
- OVERRUN_MARGIN, 16, minimum free words required before writer collision is declared.

Ports:
- clk, input, 1, block clock (same domain as writer).
- rstn, input, 1, synchronous active-low reset.
- enable, input, 1, streaming enable (control register bit).
- wr_word_addr, input, 14, writer's next-write word address (current_bram_address).
- bram_addr, output, BRAM_ADDR_WIDTH, byte address {rd_word, 2'b00}.
- bram_en, output, 1, port B read enable.
- bram_dout, input, 32, port B read data; 1-cycle latency.
- bram_clk, output, 1, tied to clk.
- bram_rst, output, 1, equals ~rstn.
- m_axis_tdata, output, 32, stream data.
- m_axis_tvalid, output, 1, stream valid.
- m_axis_tready, input, 1, stream ready.
- m_axis_tlast, output, 1, last word of packet.
- status_rd_ptr, output, 14, current read word pointer.
- status_pkt_count, output, 32, packets fully transferred (tlast handshakes).
- status_overrun, output, 1, sticky overrun flag.

Behaviour:
- Synchronous reset, applied on rstn=0 at a clk edge:
  - state=IDLE; rd_ptr=0; pkt_count=0; overrun=0.
  - bram_en=0; tvalid=0; tlast=0; tdata=0.
  - Output buffer emptied. Reset mid-packet abandons the packet with no tlast.
- avail = (wr_word_addr - rd_ptr) mod BRAM_DEPTH_WORDS, 14-bit unsigned wrap subtraction.
- States:
  - IDLE: outputs quiet. When enable=1: rd_ptr<=wr_word_addr (discard stale data), word_cnt<=0, next state WAIT.
  - WAIT: if enable=0, go to IDLE. Else if avail >= PACKET_WORDS, go to STREAM.
  - STREAM: issue one read per cycle while (buffer occupancy + in-flight reads) < 2 and issued words < PACKET_WORDS.
    - Each issue: bram_en=1, bram_addr={rd_ptr,2'b00}; rd_ptr increments with wrap at BRAM_DEPTH_WORDS-1 -> 0.
    - Data captured into a 2-entry output buffer the cycle after issue.
    - The tvalid/tready handshake pops the buffer. tlast=1 on the PACKET_WORDS-th word.
    - On the tlast handshake: pkt_count+1 (wraps at 2^32), then go to WAIT. If enable=0 at that point, go to IDLE.
    - enable deasserting mid-packet does not truncate the packet; it completes first.
  - HALT: entered from WAIT or STREAM when avail > BRAM_DEPTH_WORDS - OVERRUN_MARGIN (writer about to overtake).
    - Sets overrun=1.
    - A packet in progress is finished from already-read data, with tlast forced on its final buffered word. No further reads.
    - Stays in HALT until enable=0, then goes to IDLE. overrun clears only on the IDLE->WAIT transition or reset.
- Throughput: 1 word/cycle sustained when tready=1. First tvalid occurs 2 cycles after entering STREAM.
- tdata/tvalid/tlast are stable while tvalid=1 and tready=0. Throughput returns to full rate after stalls, with no bubbles.
- bram_en=0 whenever no read is issued. Port B never writes (no WE port).
- Packets may straddle the ring wrap; addresses follow rd_ptr wrap.

Optional Feature:
- STREAM_SEQ_HEADER_EN defined:
  - Each packet is prefixed with one header word {16'hA5A5, seq[15:0]}, where seq is pkt_count low 16 bits at packet start.
  - Stream packet length becomes PACKET_WORDS+1; tlast stays on the last data word.
  - The header is injected without a BRAM read, with zero extra bubble cycles.
- Undefined: no header; packets are exactly PACKET_WORDS words.

Test Plan:
- Reset/idle: rstn=0 for 3 cycles with enable=1 -> all outputs 0, status_rd_ptr=0, no bram_en.
- Single packet: enable=1 at wr_word_addr=0, BRAM word n = n, then wr_word_addr=144 with tready=1 ->
  - 144 beats, tdata 0..143, tlast only on 143.
  - First tvalid 2 cycles after STREAM entry.
  - pkt_count=1, rd_ptr=144.
- Backpressure: tready toggles 1,0,0,1 repeatedly over 288 available words -> no lost or duplicated words; data held while stalled; pkt_count=2.
- Ring wrap: start rd_ptr=16320, wr_word_addr advances to 80 -> addresses 16320..16383 then 0..79; tdata continuous; tlast on word from address 79.
- Overrun: writer leads by 16370 words -> status_overrun=1, state HALT, bram_en stays 0. enable 0 then 1 -> overrun=0, rd_ptr=wr_word_addr.
- With STREAM_SEQ_HEADER_EN: two packets -> 145 beats each; first beats 0xA5A50000 and 0xA5A50001.

Source files
------------

// File: rtl/bram_packet_streamer.sv
// bram_packet_streamer
// Reads fixed-size packets out of the shared BRAM ring buffer through port B.
// A packet is read once the writer's word pointer shows that a complete packet
// is present. The packets are sent out as an AXI4-Stream master.
//
// Ports:
//   clk, rstn         block clock, synchronous active-low reset
//   enable            streaming enable
//   wr_word_addr      writer's next-write word address
//   bram_*            port B (read only): addr (byte), en, dout (1-cycle latency),
//                     clk (tied to clk), rst (~rstn)
//   m_axis_*          stream master: tdata, tvalid, tready, tlast
//   status_*          read pointer, completed packet count, sticky overrun flag
//
// Optional build macro: STREAM_SEQ_HEADER_EN. It prefixes each packet with the
// header word {16'hA5A5, pkt_count[15:0]}. The header does not use a BRAM read.
module bram_packet_streamer #(
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_DEPTH_WORDS = 16384,
  parameter int PACKET_WORDS     = 144,
  parameter int OVERRUN_MARGIN   = 16,
  localparam int PTR_W           = $clog2(BRAM_DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [PTR_W-1:0]           wr_word_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic                       bram_en,
  input  logic [31:0]                bram_dout,
  output logic                       bram_clk,
  output logic                       bram_rst,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [PTR_W-1:0]           status_rd_ptr,
  output logic [31:0]                status_pkt_count,
  output logic                       status_overrun
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(PACKET_WORDS + 1);
  localparam logic [PTR_W-1:0] PKT_AVAIL = PTR_W'(PACKET_WORDS);
  localparam logic [PTR_W-1:0] OVR_LIMIT = PTR_W'(BRAM_DEPTH_WORDS - OVERRUN_MARGIN);
  localparam logic [CNT_W-1:0] PKT_LEN   = CNT_W'(PACKET_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PACKET_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, HALT} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   avail;
  logic               over;
  logic [CNT_W-1:0]   iss_cnt;
  logic [31:0]        pkt_count;
  logic               overrun;

  logic               issue;
  logic               rd_vld_p1;
  logic               rd_last_p1;
  logic [DATA_W-1:0]  buf_data_p2 [2];
  logic               buf_last_p2 [2];
  logic [1:0]         occ_p2;
  logic               hdr_due;
  logic               push, pop, tlast_hs, wr_idx;
  logic [DATA_W-1:0]  push_data;
  logic               push_last;
  logic [2:0]         load;

  assign bram_clk         = clk;
  assign bram_rst         = ~rstn;
  assign bram_addr        = BRAM_ADDR_WIDTH'({rd_ptr, 2'b00});
  assign status_rd_ptr    = rd_ptr;
  assign status_pkt_count = pkt_count;
  assign status_overrun   = overrun;

  // The subtraction wraps modulo the ring size because the width is exactly PTR_W.
  assign avail = wr_word_addr - rd_ptr;
  assign over  = (avail > OVR_LIMIT);

  assign pop      = m_axis_tvalid & m_axis_tready;
  assign tlast_hs = pop & m_axis_tlast;

  // A read is issued only when its data is sure to have a free buffer slot.
  // The count includes buffered words, the read in flight and a pending
  // header, minus any word that is popped in this cycle.
  assign load  = 3'(occ_p2) + 3'(rd_vld_p1) + 3'(hdr_due) - 3'(pop);
  assign issue = (state == STREAM) && (iss_cnt < PKT_LEN) && (load < 3'd2);

`ifdef STREAM_SEQ_HEADER_EN
  assign push_data = rd_vld_p1 ? bram_dout : {16'hA5A5, pkt_count[15:0]};
  assign push_last = rd_vld_p1 & rd_last_p1;
`else
  assign hdr_due   = 1'b0;
  assign push_data = bram_dout;
  assign push_last = rd_last_p1;
`endif
  assign push   = rd_vld_p1 | hdr_due;
  assign wr_idx = (occ_p2 == 2'd2) || ((occ_p2 == 2'd1) && !pop);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable)                 state_nxt = IDLE;
        else if (over)               state_nxt = HALT;
        else if (avail >= PKT_AVAIL) state_nxt = STREAM;
      end
      // A packet always completes, even when enable drops during the packet.
      STREAM: begin
        if (tlast_hs)  state_nxt = enable ? WAIT : IDLE;
        else if (over) state_nxt = HALT;
      end
      HALT:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bram_en       = issue;
    m_axis_tvalid = (occ_p2 != 2'd0) && (state != IDLE);
    m_axis_tdata  = m_axis_tvalid ? buf_data_p2[0] : '0;
    // In HALT the last buffered word closes the packet. No more reads follow it.
    m_axis_tlast  = m_axis_tvalid &
                    (buf_last_p2[0] | ((state == HALT) && (occ_p2 == 2'd1) && !rd_vld_p1));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr    <= '0;
      pkt_count <= '0;
      overrun   <= 1'b0;
      iss_cnt   <= '0;
      rd_vld_p1 <= 1'b0;
      occ_p2    <= 2'd0;
    end else begin
      rd_vld_p1 <= issue;
      if (state == IDLE && enable) rd_ptr <= wr_word_addr;
      else if (issue)              rd_ptr <= rd_ptr + 1'b1;
      if (state == WAIT && state_nxt == STREAM) iss_cnt <= '0;
      else if (issue)                           iss_cnt <= iss_cnt + 1'b1;
      if (tlast_hs) pkt_count <= pkt_count + 32'd1;
      if (state == IDLE && enable) overrun <= 1'b0;
      else if (state_nxt == HALT)  overrun <= 1'b1;
      if (state == IDLE) occ_p2 <= 2'd0;
      else               occ_p2 <= occ_p2 + 2'(push) - 2'(pop);
    end
  end

`ifdef STREAM_SEQ_HEADER_EN
  always_ff @(posedge clk) begin
    if (!rstn) hdr_due <= 1'b0;
    else       hdr_due <= (state == WAIT) && (state_nxt == STREAM);
  end
`endif

  // ---- stage p1: read in flight, BRAM data valid in the next cycle ----
  always_ff @(posedge clk) begin
    rd_last_p1 <= (iss_cnt == LAST_IDX);
  end

  // ---- stage p2: two-entry output buffer, entry 0 is the head ----
  always_ff @(posedge clk) begin
    if (pop) begin
      buf_data_p2[0] <= buf_data_p2[1];
      buf_last_p2[0] <= buf_last_p2[1];
    end
    if (push) begin
      if (wr_idx) begin
        buf_data_p2[1] <= push_data;
        buf_last_p2[1] <= push_last;
      end else begin
        buf_data_p2[0] <= push_data;
        buf_last_p2[0] <= push_last;
      end
    end
  end

endmodule

// File: tb/tb_bram_packet_streamer.sv
module tb_bram_packet_streamer;

`ifdef STREAM_SEQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int PKT   = 144;
  localparam int BEATS = PKT + HDR;
  localparam int DEPTH = 16384;

  logic        clk, rstn, enable;
  logic [13:0] wr_word_addr;
  logic [15:0] bram_addr;
  logic        bram_en, bram_clk, bram_rst;
  logic [31:0] bram_dout;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [13:0] status_rd_ptr;
  logic [31:0] status_pkt_count;
  logic        status_overrun;

  bram_packet_streamer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .wr_word_addr(wr_word_addr),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
    .bram_clk(bram_clk), .bram_rst(bram_rst),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .status_rd_ptr(status_rd_ptr), .status_pkt_count(status_pkt_count),
    .status_overrun(status_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: word n holds n, and the read data has one cycle of latency.
  logic [31:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = i;
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[15:2]];

  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int seq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic push_pkt(input int start);
    exp_t e;
`ifdef STREAM_SEQ_HEADER_EN
    e.d = {16'hA5A5, 16'(seq)}; e.l = 1'b0; q.push_back(e);
`endif
    seq++;
    for (int k = 0; k < PKT; k++) begin
      e.d = 32'((start + k) % DEPTH);
      e.l = (k == PKT - 1);
      q.push_back(e);
    end
  endtask

  // Consumes nbeats handshakes. mode 0: tready always 1. mode 1: tready
  // follows the pattern 1,0,0,1. It records the first bram_en cycle, its
  // address and the first tvalid cycle.
  task automatic stream(input int nbeats, input int mode,
                        output int t_en, output int t_vld, output logic [15:0] a_en);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    exp_t e;
    t_en = -1; t_vld = -1; a_en = '0;
    while (got < nbeats && cyc < 3000) begin
      m_axis_tready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(negedge clk);
      if (bram_en && t_en < 0) begin t_en = cyc; a_en = bram_addr; end
      if (m_axis_tvalid && t_vld < 0) t_vld = cyc;
      if (stalled) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", m_axis_tdata, held_d);
        chk("stall_last", 32'(m_axis_tlast), 32'(held_l));
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata; held_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("tdata", m_axis_tdata, e.d);
          chk("tlast", 32'(m_axis_tlast), 32'(e.l));
        end
        got++;
      end
      cycle();
      cyc++;
    end
    chk("beats_before_timeout", 32'(got), 32'(nbeats));
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {30'd0, m_axis_tvalid, bram_en}, 32'd0);
      cycle();
    end
  endtask

  int t_en, t_vld;
  logic [15:0] a_en;

  initial begin
    rstn = 1'b0; enable = 1'b1; wr_word_addr = '0; m_axis_tready = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_bram_rst", 32'(bram_rst), 32'd1);
    chk("rst_rd_ptr", 32'(status_rd_ptr), 32'd0);
    chk("rst_pkt_count", status_pkt_count, 32'd0);
    chk("rst_overrun", 32'(status_overrun), 32'd0);
    cycle();
    rstn = 1'b1;
    quiet(3, "wait_empty_quiet");

    // Single packet
    wr_word_addr = 14'd144;
    push_pkt(0);
    stream(BEATS, 0, t_en, t_vld, a_en);
    chk("first_addr", 32'(a_en), 32'd0);
    chk("first_valid_latency", 32'(t_vld - t_en), 32'(2 - HDR));
    quiet(3, "after_pkt1_quiet");
    chk("pkt_count_1", status_pkt_count, 32'd1);
    chk("rd_ptr_1", 32'(status_rd_ptr), 32'd144);

    // Backpressure across two packets
    wr_word_addr = 14'd432;
    push_pkt(144);
    push_pkt(288);
    stream(2 * BEATS, 1, t_en, t_vld, a_en);
    m_axis_tready = 1'b1;
    quiet(3, "after_bp_quiet");
    chk("pkt_count_bp", status_pkt_count, 32'd3);
    chk("rd_ptr_bp", 32'(status_rd_ptr), 32'd432);

    // Ring wrap
    enable = 1'b0;
    repeat (2) cycle();
    wr_word_addr = 14'd16320;
    enable = 1'b1;
    repeat (2) cycle();
    chk("rd_ptr_resync", 32'(status_rd_ptr), 32'd16320);
    wr_word_addr = 14'd80;
    push_pkt(16320);
    stream(BEATS, 0, t_en, t_vld, a_en);
    chk("wrap_first_addr", 32'(a_en), 32'(16320 * 4));
    quiet(2, "after_wrap_quiet");
    chk("rd_ptr_wrap", 32'(status_rd_ptr), 32'd80);
    chk("pkt_count_wrap", status_pkt_count, 32'd4);

    // Overrun: the writer leads by 16370 words
    wr_word_addr = 14'((80 + 16370) % DEPTH);
    repeat (2) cycle();
    chk("overrun_set", 32'(status_overrun), 32'd1);
    quiet(8, "halt_quiet");
    enable = 1'b0;
    repeat (2) cycle();
    chk("overrun_sticky_idle", 32'(status_overrun), 32'd1);
    enable = 1'b1;
    repeat (2) cycle();
    chk("overrun_cleared", 32'(status_overrun), 32'd0);
    chk("rd_ptr_after_overrun", 32'(status_rd_ptr), 32'd66);

    // Enable drops mid-packet: the packet still completes, then IDLE
    wr_word_addr = 14'd210;
    push_pkt(66);
    m_axis_tready = 1'b0;
    repeat (5) cycle();
    enable = 1'b0;
    stream(BEATS, 0, t_en, t_vld, a_en);
    wr_word_addr = 14'd500;
    quiet(5, "idle_after_disable_quiet");
    chk("pkt_count_final", status_pkt_count, 32'd5);
    chk("rd_ptr_final", 32'(status_rd_ptr), 32'd210);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
